// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline-stage register.
package pipe_pkg;

    // Occupancy of a stage: EMPTY (bubble), ONE (output entry), TWO (output + skid entry).
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_e;

    // MIPS sll $0,$0,0 encodes as all zeros.
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
    // Default bubble payload: {instruction, next_address}.
    localparam logic [63:0] NOP_PAYLOAD = {NOP_INSTR, 32'h0000_0000};

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module pipe_sat_counter
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    // Clear has priority; increment stops at the all-ones ceiling.
    always_ff @(posedge clk) begin
        if (clr) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline-stage register with valid/ready handshake, hold, flush,
// optional 2-entry skid buffer and a saturating stall-cycle counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W    = 64,
    parameter logic [DATA_W-1:0] NOP_VALUE = DATA_W'(NOP_PAYLOAD),
    parameter int unsigned       SKID      = 1,
    parameter int unsigned       CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    pipe_state_e       state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_data;
    logic              acc_in, acc_out;

    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;
    // hold acts exactly like a forced out_ready=0.
    assign acc_out   = out_valid & out_ready & ~hold;
    assign acc_in    = in_valid & in_ready;

    if (SKID != 0) begin : g_skid
        logic [DATA_W-1:0] skid_q;
        logic              skid_valid;

        assign skid_valid = (state_q == ST_TWO);
        // Registered-only ready: no combinational path from out_ready to in_ready.
        assign in_ready   = ~skid_valid & ~flush & ~rst;
        assign skid_data  = skid_q;

        // Skid entry captures a new beat when the output entry is stuck.
        always_ff @(posedge clk) begin
            if (rst || flush) begin
                skid_q <= NOP_VALUE;
            end else if ((state_q == ST_ONE) && acc_in && !acc_out) begin
                skid_q <= in_data;
            end
        end
    end else begin : g_no_skid
        assign in_ready  = (~out_valid | acc_out) & ~flush & ~rst;
        assign skid_data = NOP_VALUE;
    end

    // Next-state and output-entry selection; flush overrides every transfer.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = NOP_VALUE;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (acc_in) begin
                        state_d = ST_ONE;
                        main_d  = in_data;
                    end
                end
                ST_ONE: begin
                    if (acc_in && acc_out) begin
                        main_d = in_data;
                    end else if (acc_in) begin
                        // Only reachable with a skid entry; the beat parks behind main.
                        state_d = ST_TWO;
                    end else if (acc_out) begin
                        state_d = ST_EMPTY;
                        main_d  = NOP_VALUE;
                    end
                end
                ST_TWO: begin
                    if (acc_out) begin
                        state_d = ST_ONE;
                        main_d  = skid_data;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = NOP_VALUE;
                end
            endcase
        end
    end

    // State and output-entry registers; reset wins over flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= NOP_VALUE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
        end
    end

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (out_valid & (~out_ready | hold) & ~flush),
        .count (stall_cnt)
    );

endmodule
